// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Holds the occupancy state enum used by the skid-buffered stage and the
// default control/data widths of each CPU stage boundary.
package pipe_pkg;

  // Occupancy of a skid-buffered stage: nothing, main only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Stage boundaries that instantiate pipe_stage_reg.
  typedef enum logic [1:0] {
    STAGE_IF_ID  = 2'd0,
    STAGE_ID_EX  = 2'd1,
    STAGE_EX_MEM = 2'd2,
    STAGE_MEM_WB = 2'd3
  } pipe_stage_e;

  // IF/ID: predicted-taken + valid-instruction flags; pc 32 + instr 32.
  localparam int unsigned IFID_CTRL_W  = 2;
  localparam int unsigned IFID_DATA_W  = 64;
  // ID/EX: alu_src, branch, jump, alu_op(2), MemRead, MemWrite, RegWrite;
  // pc 32 + rs1 32 + rs2 32 + imm 32 + rd 5.
  localparam int unsigned IDEX_CTRL_W  = 8;
  localparam int unsigned IDEX_DATA_W  = 133;
  // EX/MEM: MemRead, MemWrite, RegWrite, mem_to_reg; alu 32 + store 32 + rd 5.
  localparam int unsigned EXMEM_CTRL_W = 4;
  localparam int unsigned EXMEM_DATA_W = 69;
  // MEM/WB: RegWrite, mem_to_reg; result 32 + rd 5.
  localparam int unsigned MEMWB_CTRL_W = 2;
  localparam int unsigned MEMWB_DATA_W = 37;

  // Widths used when a stage is instantiated without overrides.
  localparam int unsigned DEFAULT_CTRL_W = EXMEM_CTRL_W;
  localparam int unsigned DEFAULT_DATA_W = EXMEM_DATA_W;

  // Control-field width for a given stage boundary.
  function automatic int unsigned stage_ctrl_w(pipe_stage_e stage);
    int unsigned w;
    w = DEFAULT_CTRL_W;
    case (stage)
      STAGE_IF_ID:  w = IFID_CTRL_W;
      STAGE_ID_EX:  w = IDEX_CTRL_W;
      STAGE_EX_MEM: w = EXMEM_CTRL_W;
      STAGE_MEM_WB: w = MEMWB_CTRL_W;
      default:      w = DEFAULT_CTRL_W;
    endcase
    return w;
  endfunction

  // Data-field width for a given stage boundary.
  function automatic int unsigned stage_data_w(pipe_stage_e stage);
    int unsigned w;
    w = DEFAULT_DATA_W;
    case (stage)
      STAGE_IF_ID:  w = IFID_DATA_W;
      STAGE_ID_EX:  w = IDEX_DATA_W;
      STAGE_EX_MEM: w = EXMEM_DATA_W;
      STAGE_MEM_WB: w = MEMWB_DATA_W;
      default:      w = DEFAULT_DATA_W;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, stall and flush.
// SKID=1: two-entry skid buffer (main feeds outputs, skid is second) with
//         in_ready_o derived from registered occupancy only.
// SKID=0: single register, in_ready_o passes through from out_ready_i.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   hold_i  - stall, freezes all state and blocks both transfers
//   flush_i - drops held entries and the current input
//   in_valid_i / in_ready_o / in_ctrl_i / in_data_i   - upstream side
//   out_valid_o / out_ready_i / out_ctrl_o / out_data_o - downstream side
// Control bits read as zero whenever no valid entry is presented, so a
// bubble never asserts MemRead/MemWrite/RegWrite downstream.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEFAULT_CTRL_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic              in_fire;
  logic              out_fire;
  logic              head_valid;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;

  // Handshake qualification; flush and hold suppress both sides.
  assign in_fire  = in_valid_i & in_ready_o & ~flush_i;
  assign out_fire = head_valid & out_ready_i & ~hold_i & ~flush_i;

  // Head presentation with control masking for bubbles.
  assign out_valid_o = head_valid;
  assign out_ctrl_o  = head_ctrl & {CTRL_W{head_valid}};
  assign out_data_o  = head_data;

  if (SKID) begin : g_skid
    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;

    // Ready depends only on registered occupancy and the stall input.
    assign in_ready_o = (state_q != FULL) & ~hold_i;
    assign head_valid = (state_q != EMPTY);
    assign head_ctrl  = main_ctrl_q;
    assign head_data  = main_data_q;

    // State and payload registers.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q     <= EMPTY;
        main_ctrl_q <= '0;
        main_data_q <= '0;
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else begin
        state_q     <= state_d;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
      end
    end

    // Next-state and payload steering.
    always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush_i) begin
        // Data is left stale; only control must not leak from a bubble.
        state_d     = EMPTY;
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
      end else if (!hold_i) begin
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_d     = HALF;
              main_ctrl_d = in_ctrl_i;
              main_data_d = in_data_i;
            end
          end
          HALF: begin
            if (in_fire && out_fire) begin
              main_ctrl_d = in_ctrl_i;
              main_data_d = in_data_i;
            end else if (in_fire) begin
              state_d     = FULL;
              skid_ctrl_d = in_ctrl_i;
              skid_data_d = in_data_i;
            end else if (out_fire) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            // in_ready_o is low here, so only the drain path exists.
            if (out_fire) begin
              state_d     = HALF;
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
            end
          end
          default: begin
            state_d = EMPTY;
          end
        endcase
      end
    end
  end else begin : g_single
    logic              valid_q;
    logic              valid_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Accept when empty or when the head leaves this same cycle.
    assign in_ready_o = (~valid_q | out_ready_i) & ~hold_i;
    assign head_valid = valid_q;
    assign head_ctrl  = ctrl_q;
    assign head_data  = data_q;

    // Single entry register.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        ctrl_q  <= ctrl_d;
        data_q  <= data_d;
      end
    end

    // Load on accept, empty on consume-without-refill, clear on flush.
    always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (flush_i) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else if (in_fire) begin
        valid_d = 1'b1;
        ctrl_d  = in_ctrl_i;
        data_d  = in_data_i;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: one skid-buffered instance and one
// single-register instance, each tracked by a queue of accepted entries.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned CW = DEFAULT_CTRL_W;
  localparam int unsigned DW = DEFAULT_DATA_W;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst;

  logic          a_hold, a_flush, a_valid, a_irdy, a_ov, a_ordy;
  logic [CW-1:0] a_ctrl, a_oc;
  logic [DW-1:0] a_data, a_od;
  logic          b_hold, b_flush, b_valid, b_irdy, b_ov, b_ordy;
  logic [CW-1:0] b_ctrl, b_oc;
  logic [DW-1:0] b_data, b_od;

  entry_t q_a[$];
  entry_t q_b[$];
  int     passed = 0;
  int     total  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_skid (
    .clk_i(clk), .rst_i(rst), .hold_i(a_hold), .flush_i(a_flush),
    .in_valid_i(a_valid), .in_ready_o(a_irdy), .in_ctrl_i(a_ctrl), .in_data_i(a_data),
    .out_valid_o(a_ov), .out_ready_i(a_ordy), .out_ctrl_o(a_oc), .out_data_o(a_od)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_single (
    .clk_i(clk), .rst_i(rst), .hold_i(b_hold), .flush_i(b_flush),
    .in_valid_i(b_valid), .in_ready_o(b_irdy), .in_ctrl_i(b_ctrl), .in_data_i(b_data),
    .out_valid_o(b_ov), .out_ready_i(b_ordy), .out_ctrl_o(b_oc), .out_data_o(b_od)
  );

  // One cycle on the skid instance: drive after negedge, sample 1 time unit
  // later, record accepted entries, then advance to the next negedge.
  task automatic step_a(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic hold, input logic flush,
                        output logic ir, output logic ov, output logic [CW-1:0] oc,
                        output logic [DW-1:0] od, output logic ofire);
    a_valid = v; a_ctrl = c; a_data = d; a_ordy = ordy; a_hold = hold; a_flush = flush;
    #1;
    ir = a_irdy; ov = a_ov; oc = a_oc; od = a_od;
    ofire = ov & ordy & ~hold & ~flush;
    if (flush) q_a.delete();
    else if (v && ir) q_a.push_back(entry_t'{ctrl: c, data: d});
    @(negedge clk);
  endtask

  // Same for the single-register instance.
  task automatic step_b(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic hold, input logic flush,
                        output logic ir, output logic ov, output logic [CW-1:0] oc,
                        output logic [DW-1:0] od, output logic ofire);
    b_valid = v; b_ctrl = c; b_data = d; b_ordy = ordy; b_hold = hold; b_flush = flush;
    #1;
    ir = b_irdy; ov = b_ov; oc = b_oc; od = b_od;
    ofire = ov & ordy & ~hold & ~flush;
    if (flush) q_b.delete();
    else if (v && ir) q_b.push_back(entry_t'{ctrl: c, data: d});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic ir, ov, of;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    rst = 1'b1;
    b_valid = 1'b1; b_ctrl = CW'(4'hF); b_data = DW'(69'h1_2345_6789); b_ordy = 1'b1;
    for (int i = 0; i < 2; i++)
      step_a(1'b1, CW'(4'hF), DW'(69'h1_2345_6789), 1'b1, 1'b0, 1'b0, ir, ov, oc, od, of);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    total++; if (a_ov !== 1'b0) $display("FAIL reset_a_valid: got %b want 0", a_ov); else passed++;
    total++; if (a_oc !== '0) $display("FAIL reset_a_ctrl: got %0h want 0", a_oc); else passed++;
    total++; if (a_od !== '0) $display("FAIL reset_a_data: got %0h want 0", a_od); else passed++;
    total++; if (a_irdy !== 1'b1) $display("FAIL reset_a_ready: got %b want 1", a_irdy); else passed++;
    total++; if (b_ov !== 1'b0) $display("FAIL reset_b_valid: got %b want 0", b_ov); else passed++;
    total++; if (b_oc !== '0) $display("FAIL reset_b_ctrl: got %0h want 0", b_oc); else passed++;
    total++; if (b_od !== '0) $display("FAIL reset_b_data: got %0h want 0", b_od); else passed++;
    total++; if (b_irdy !== 1'b1) $display("FAIL reset_b_ready: got %b want 1", b_irdy); else passed++;
    @(negedge clk);
    q_a.delete();
    q_b.delete();
  endtask

  task automatic test_stream();
    logic ir, ov, of;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    entry_t exp;
    int got = 0;
    for (int k = 0; k < 10; k++) begin
      step_a(k < 8, CW'(k + 1), DW'(k + 1), 1'b1, 1'b0, 1'b0, ir, ov, oc, od, of);
      if (k < 8) begin
        total++; if (ir !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", k, ir); else passed++;
      end
      total++;
      if (ov !== (k >= 1 && k <= 8)) $display("FAIL stream_valid[%0d]: got %b want %b", k, ov, (k >= 1 && k <= 8));
      else passed++;
      if (!ov) begin
        total++; if (oc !== '0) $display("FAIL stream_bubble_ctrl[%0d]: got %0h want 0", k, oc); else passed++;
      end
      if (of) begin
        total++;
        if (q_a.size() == 0) $display("FAIL stream_extra: got data %0h want no output", od);
        else begin
          exp = q_a.pop_front();
          if ({oc, od} !== exp || od !== DW'(k))
            $display("FAIL stream_data[%0d]: got %0h/%0h want %0h/%0h", k, oc, od, exp.ctrl, exp.data);
          else passed++;
          got++;
        end
      end
    end
    total++; if (got !== 8) $display("FAIL stream_count: got %0d want 8", got); else passed++;
  endtask

  task automatic test_backpressure();
    logic ir, ov, of, exp_ir, exp_ov, saw_stall;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    entry_t exp;
    int nxt = 1;
    int got = 0;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 10; cyc++) begin
      exp_ir = (q_a.size() < 2);
      exp_ov = (q_a.size() != 0);
      step_a(nxt <= 10, CW'(nxt), DW'(100 + nxt), !(cyc >= 3 && cyc <= 5), 1'b0, 1'b0,
             ir, ov, oc, od, of);
      total++; if (ir !== exp_ir) $display("FAIL bp_ready[%0d]: got %b want %b", cyc, ir, exp_ir); else passed++;
      total++; if (ov !== exp_ov) $display("FAIL bp_valid[%0d]: got %b want %b", cyc, ov, exp_ov); else passed++;
      if (!ir) saw_stall = 1'b1;
      if (nxt <= 10 && ir) nxt++;
      if (of) begin
        total++;
        if (q_a.size() == 0) $display("FAIL bp_extra: got data %0h want no output", od);
        else begin
          exp = q_a.pop_front();
          if ({oc, od} !== exp || od !== DW'(100 + got + 1))
            $display("FAIL bp_order: got %0h/%0h want %0h/%0h", oc, od, exp.ctrl, exp.data);
          else passed++;
          got++;
        end
      end
    end
    total++; if (got !== 10) $display("FAIL bp_count: got %0d want 10", got); else passed++;
    total++; if (saw_stall !== 1'b1) $display("FAIL bp_stall_seen: got %b want 1", saw_stall); else passed++;
  endtask

  task automatic test_hold();
    logic ir, ov, of;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    entry_t exp;
    step_a(1'b1, CW'(4'b1010), DW'(8'h55), 1'b0, 1'b0, 1'b0, ir, ov, oc, od, of);
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, CW'(4'b0110), DW'(8'h66), 1'b1, 1'b1, 1'b0, ir, ov, oc, od, of);
      total++; if (ov !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", i, ov); else passed++;
      total++; if (oc !== CW'(4'b1010)) $display("FAIL hold_ctrl[%0d]: got %0h want a", i, oc); else passed++;
      total++; if (od !== DW'(8'h55)) $display("FAIL hold_data[%0d]: got %0h want 55", i, od); else passed++;
      total++; if (ir !== 1'b0) $display("FAIL hold_ready[%0d]: got %b want 0", i, ir); else passed++;
    end
    step_a(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, ir, ov, oc, od, of);
    total++;
    if (!of || q_a.size() == 0) $display("FAIL hold_release: got fire=%b want 1", of);
    else begin
      exp = q_a.pop_front();
      if ({oc, od} !== exp || od !== DW'(8'h55))
        $display("FAIL hold_release_data: got %0h/%0h want %0h/%0h", oc, od, exp.ctrl, exp.data);
      else passed++;
    end
    step_a(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, ir, ov, oc, od, of);
    total++; if (ov !== 1'b0) $display("FAIL hold_single_fire: got valid %b want 0", ov); else passed++;
  endtask

  task automatic test_flush();
    logic ir, ov, of;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    entry_t exp;
    step_a(1'b1, CW'(4'h7), DW'(8'hA1), 1'b0, 1'b0, 1'b0, ir, ov, oc, od, of);
    step_a(1'b1, CW'(4'hE), DW'(8'hB2), 1'b0, 1'b0, 1'b0, ir, ov, oc, od, of);
    total++; if (q_a.size() !== 2) $display("FAIL flush_fill: got %0d entries want 2", q_a.size()); else passed++;
    step_a(1'b1, CW'(4'hD), DW'(8'hC3), 1'b1, 1'b1, 1'b1, ir, ov, oc, od, of);
    step_a(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, ir, ov, oc, od, of);
    total++; if (ov !== 1'b0) $display("FAIL flush_valid: got %b want 0", ov); else passed++;
    total++; if (oc !== '0) $display("FAIL flush_ctrl: got %0h want 0", oc); else passed++;
    total++; if (ir !== 1'b1) $display("FAIL flush_ready: got %b want 1", ir); else passed++;
    step_a(1'b1, CW'(4'h3), DW'(8'hD4), 1'b1, 1'b0, 1'b0, ir, ov, oc, od, of);
    total++; if (ov !== 1'b0) $display("FAIL flush_dropped: got valid %b data %0h want 0", ov, od); else passed++;
    step_a(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, ir, ov, oc, od, of);
    total++;
    if (!of || q_a.size() == 0) $display("FAIL flush_refill: got fire=%b want 1", of);
    else begin
      exp = q_a.pop_front();
      if ({oc, od} !== exp || od !== DW'(8'hD4))
        $display("FAIL flush_refill_data: got %0h/%0h want %0h/%0h", oc, od, exp.ctrl, exp.data);
      else passed++;
    end
    step_a(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, ir, ov, oc, od, of);
    total++; if (ov !== 1'b0) $display("FAIL flush_empty: got valid %b want 0", ov); else passed++;
  endtask

  task automatic test_skid0();
    // Rows: valid, out_ready, hold, data.
    logic      t_v[12]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic      t_r[12]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    logic      t_h[12]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    logic [7:0] t_d[12] = '{1, 2, 2, 3, 4, 5, 5, 5, 6, 7, 0, 0};
    logic ir, ov, of, exp_ir, exp_ov;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    entry_t exp;
    int got = 0;
    for (int i = 0; i < 12; i++) begin
      exp_ov = (q_b.size() != 0);
      exp_ir = ((q_b.size() == 0) || t_r[i]) && !t_h[i];
      step_b(t_v[i], CW'(t_d[i]), DW'(t_d[i]) << 40, t_r[i], t_h[i], 1'b0, ir, ov, oc, od, of);
      total++; if (ir !== exp_ir) $display("FAIL s0_ready[%0d]: got %b want %b", i, ir, exp_ir); else passed++;
      total++; if (ov !== exp_ov) $display("FAIL s0_valid[%0d]: got %b want %b", i, ov, exp_ov); else passed++;
      if (!exp_ov) begin
        total++; if (oc !== '0) $display("FAIL s0_bubble_ctrl[%0d]: got %0h want 0", i, oc); else passed++;
      end
      if (of) begin
        total++;
        if (q_b.size() == 0) $display("FAIL s0_extra: got data %0h want no output", od);
        else begin
          exp = q_b.pop_front();
          if ({oc, od} !== exp)
            $display("FAIL s0_data[%0d]: got %0h/%0h want %0h/%0h", i, oc, od, exp.ctrl, exp.data);
          else passed++;
          got++;
        end
      end
    end
    total++; if (got !== 7) $display("FAIL s0_count: got %0d want 7", got); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    a_hold = 1'b0; a_flush = 1'b0; a_valid = 1'b0; a_ordy = 1'b0; a_ctrl = '0; a_data = '0;
    b_hold = 1'b0; b_flush = 1'b0; b_valid = 1'b0; b_ordy = 1'b0; b_ctrl = '0; b_data = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_flush();
    test_skid0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
